// File: rtl/brake_heart_guard.sv
// Brake heartbeat watchdog with fault latch and glitch-free brake PWM.
// A missed heartbeat forces full braking until a new heartbeat or disable.
module brake_heart_guard #(
  parameter int unsigned MS_DIV  = 50000,
  parameter int unsigned PWM_DIV = 50,
  parameter int unsigned U_DLY   = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        brake_heart_pulse,
  input  logic [7:0]  brake_heart_timeout,
  input  logic        brake_heart_enable,
  input  logic [15:0] brake_ratio,
  output logic        brake_pwm,
  output logic        brake_fault,
  output logic        brake_fault_int,
  output logic [1:0]  brake_state
);

  localparam int PW = (MS_DIV > 1) ? $clog2(MS_DIV) : 1;
  localparam int DW = (PWM_DIV > 1) ? $clog2(PWM_DIV) : 1;
  // U_DLY only matters to behavioural models; it has no hardware effect.
  localparam logic [9:0] STEP_MAX = 10'(999 + U_DLY * 0);

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    RUN   = 2'b01,
    FAULT = 2'b10
  } state_t;

  state_t state, state_nxt;

  logic [PW-1:0] pre_q, pre_d;
  logic [17:0]   ms_q, ms_d;
  logic [7:0]    to_eff;
  logic [17:0]   limit;

  logic [DW-1:0] div_q;
  logic          tick;
  logic [9:0]    step_q;
  logic [9:0]    duty_q;
  logic [9:0]    ratio_c;
  logic          pwm_q;
  logic          fault_q;
  logic          int_q;

  assign to_eff  = (brake_heart_timeout == 8'd0) ? 8'd1
                                                 : brake_heart_timeout;
  assign limit   = 18'(to_eff) * 18'd1000;
  assign ratio_c = (brake_ratio > 16'd1000) ? 10'd1000
                                            : brake_ratio[9:0];
  assign tick    = (div_q == DW'(PWM_DIV - 1));

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE: begin
        if (brake_heart_enable) state_nxt = RUN;
      end
      RUN: begin
        if (!brake_heart_enable)
          state_nxt = IDLE;
        else if (!brake_heart_pulse && ms_q >= limit)
          state_nxt = FAULT;
      end
      FAULT: begin
        if (!brake_heart_enable)
          state_nxt = IDLE;
        else if (brake_heart_pulse)
          state_nxt = RUN;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Counting already starts on the IDLE->RUN edge; a pulse restarts at zero.
  always_comb begin
    pre_d = '0;
    ms_d  = '0;
    if (state_nxt == RUN && !brake_heart_pulse) begin
      if (pre_q == PW'(MS_DIV - 1)) begin
        pre_d = '0;
        ms_d  = ms_q + 18'd1;
      end else begin
        pre_d = pre_q + 1'b1;
        ms_d  = ms_q;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      pre_q   <= '0;
      ms_q    <= '0;
      fault_q <= 1'b0;
      int_q   <= 1'b0;
    end else begin
      state   <= state_nxt;
      pre_q   <= pre_d;
      ms_q    <= ms_d;
      fault_q <= (state_nxt == FAULT);
      int_q   <= (state_nxt == FAULT) && (state != FAULT);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_q  <= '0;
      step_q <= '0;
      duty_q <= '0;
      pwm_q  <= 1'b0;
    end else begin
      div_q <= tick ? '0 : div_q + 1'b1;
      if (tick) begin
        if (step_q == STEP_MAX) begin
          step_q <= '0;
          duty_q <= ratio_c;
        end else begin
          step_q <= step_q + 10'd1;
        end
      end
      pwm_q <= (state == FAULT) || (step_q < duty_q);
    end
  end

  assign brake_pwm       = pwm_q;
  assign brake_fault     = fault_q;
  assign brake_fault_int = int_q;
  assign brake_state     = state;

endmodule

// File: tb/tb_brake_heart_guard.sv
// Bench for brake_heart_guard: vector table, directed corner cases and
// randomized traffic against an elapsed-time reference model.
module tb_brake_heart_guard;

  localparam int MSD = 4;
  localparam int PWD = 1;

  logic        clk;
  logic        rst_n;
  logic        pulse;
  logic [7:0]  timeout;
  logic        enable;
  logic [15:0] ratio;
  logic        brake_pwm;
  logic        brake_fault;
  logic        brake_fault_int;
  logic [1:0]  brake_state;

  brake_heart_guard #(
    .MS_DIV (MSD),
    .PWM_DIV(PWD),
    .U_DLY  (1)
  ) dut (
    .clk                (clk),
    .rst_n              (rst_n),
    .brake_heart_pulse  (pulse),
    .brake_heart_timeout(timeout),
    .brake_heart_enable (enable),
    .brake_ratio        (ratio),
    .brake_pwm          (brake_pwm),
    .brake_fault        (brake_fault),
    .brake_fault_int    (brake_fault_int),
    .brake_state        (brake_state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: mode 0 idle, 1 run, 2 fault; cnt = cycles counted
  // since the watchdog was last cleared; pc = edges since reset release.
  int m_st, m_cnt, m_pc, m_duty;
  logic m_pwm, m_fault, m_int;

  task automatic chk(string nm, logic [15:0] act, logic [15:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      if (n_fail <= 30)
        $display("FAIL %s: got %0h expected %0h at %0t",
                 nm, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_st = 0; m_cnt = 0; m_pc = 0; m_duty = 0;
    m_pwm = 0; m_fault = 0; m_int = 0;
  endtask

  task automatic model_update();
    int lim, ost, ostep;
    lim   = ((timeout == 0) ? 1 : int'(timeout)) * 1000;
    ost   = m_st;
    ostep = (m_pc / PWD) % 1000;
    m_pwm = (ost == 2) || (ostep < m_duty);
    if ((m_pc + 1) % (PWD * 1000) == 0)
      m_duty = (ratio > 16'd1000) ? 1000 : int'(ratio);
    m_pc++;
    if (!enable) begin
      m_st = 0; m_cnt = 0;
    end else if (ost == 0) begin
      m_st = 1; m_cnt = pulse ? 0 : 1;
    end else if (ost == 1) begin
      if (pulse) m_cnt = 0;
      else if (m_cnt / MSD >= lim) begin m_st = 2; m_cnt = 0; end
      else m_cnt++;
    end else if (pulse) begin
      m_st = 1; m_cnt = 0;
    end
    m_fault = (m_st == 2);
    m_int   = (m_st == 2) && (ost != 2);
  endtask

  task automatic check_model();
    chk("m_state", 16'(brake_state), 16'(m_st));
    chk("m_fault", 16'(brake_fault), 16'(m_fault));
    chk("m_int",   16'(brake_fault_int), 16'(m_int));
    chk("m_pwm",   16'(brake_pwm), 16'(m_pwm));
  endtask

  task automatic tick();
    @(posedge clk);
    model_update();
    #1;
    check_model();
  endtask

  task automatic ticks(int n);
    for (int k = 0; k < n; k++) tick();
  endtask

  typedef struct {
    logic        en;
    logic        pl;
    logic [7:0]  to;
    logic [15:0] ra;
    int          n;
    logic [1:0]  st;
    logic        flt;
    logic        irq;
    logic        pwm;
  } vec_t;

  vec_t vt[18];
  logic any_flt;

  initial begin
    vt[0]  = '{1'b0, 1'b0, 8'd1, 16'd250,    10,   2'd0, 1'b0, 1'b0, 1'b0};
    vt[1]  = '{1'b1, 1'b0, 8'd1, 16'd250,    1,    2'd1, 1'b0, 1'b0, 1'b0};
    vt[2]  = '{1'b1, 1'b0, 8'd1, 16'd250,    3988, 2'd1, 1'b0, 1'b0, 1'b0};
    vt[3]  = '{1'b1, 1'b0, 8'd1, 16'd250,    11,   2'd1, 1'b0, 1'b0, 1'b1};
    vt[4]  = '{1'b1, 1'b0, 8'd1, 16'd250,    1,    2'd2, 1'b1, 1'b1, 1'b1};
    vt[5]  = '{1'b1, 1'b0, 8'd1, 16'd250,    300,  2'd2, 1'b1, 1'b0, 1'b1};
    vt[6]  = '{1'b1, 1'b1, 8'd1, 16'd250,    1,    2'd1, 1'b0, 1'b0, 1'b1};
    vt[7]  = '{1'b1, 1'b0, 8'd1, 16'd250,    1,    2'd1, 1'b0, 1'b0, 1'b0};
    vt[8]  = '{1'b0, 1'b0, 8'd1, 16'd250,    1,    2'd0, 1'b0, 1'b0, 1'b0};
    vt[9]  = '{1'b0, 1'b0, 8'd1, 16'hFFFF,   1700, 2'd0, 1'b0, 1'b0, 1'b1};
    vt[10] = '{1'b0, 1'b0, 8'd1, 16'd0,      1000, 2'd0, 1'b0, 1'b0, 1'b0};
    vt[11] = '{1'b0, 1'b0, 8'd1, 16'd700,    1000, 2'd0, 1'b0, 1'b0, 1'b1};
    vt[12] = '{1'b0, 1'b0, 8'd1, 16'd700,    686,  2'd0, 1'b0, 1'b0, 1'b1};
    vt[13] = '{1'b0, 1'b0, 8'd1, 16'd700,    1,    2'd0, 1'b0, 1'b0, 1'b0};
    vt[14] = '{1'b1, 1'b0, 8'd0, 16'd700,    1,    2'd1, 1'b0, 1'b0, 1'b0};
    vt[15] = '{1'b1, 1'b0, 8'd0, 16'd700,    3999, 2'd1, 1'b0, 1'b0, 1'b0};
    vt[16] = '{1'b1, 1'b0, 8'd0, 16'd700,    1,    2'd2, 1'b1, 1'b1, 1'b0};
    vt[17] = '{1'b0, 1'b1, 8'd0, 16'd700,    1,    2'd0, 1'b0, 1'b0, 1'b1};

    pulse = 0; timeout = 8'd1; enable = 0; ratio = 16'd250;
    rst_n = 1'b1;
    #2 rst_n = 1'b0;
    #1;
    chk("rst_state", 16'(brake_state), 16'd0);
    chk("rst_fault", 16'(brake_fault), 16'd0);
    chk("rst_int",   16'(brake_fault_int), 16'd0);
    chk("rst_pwm",   16'(brake_pwm), 16'd0);
    model_reset();
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 18; i++) begin
      enable  = vt[i].en;
      timeout = vt[i].to;
      ratio   = vt[i].ra;
      pulse   = vt[i].pl;
      tick();
      pulse = 1'b0;
      ticks(vt[i].n - 1);
      chk($sformatf("vec%0d_state", i), 16'(brake_state), 16'(vt[i].st));
      chk($sformatf("vec%0d_fault", i), 16'(brake_fault), 16'(vt[i].flt));
      chk($sformatf("vec%0d_int", i), 16'(brake_fault_int), 16'(vt[i].irq));
      chk($sformatf("vec%0d_pwm", i), 16'(brake_pwm), 16'(vt[i].pwm));
    end

    // Heartbeat on the very cycle the limit is reached keeps RUN.
    enable = 1'b1; timeout = 8'd1;
    tick();
    ticks(3999);
    pulse = 1'b1;
    tick();
    pulse = 1'b0;
    chk("hb_at_limit", 16'(brake_state), 16'd1);
    chk("hb_at_limit_flt", 16'(brake_fault), 16'd0);

    // Regular heartbeats hold off the watchdog; then it expires.
    any_flt = 1'b0;
    for (int r = 0; r < 7; r++) begin
      for (int k = 0; k < 2999; k++) begin
        tick();
        any_flt |= brake_fault;
      end
      pulse = 1'b1;
      tick();
      pulse = 1'b0;
      any_flt |= brake_fault;
    end
    chk("hb_no_fault", 16'(any_flt), 16'd0);
    ticks(4000);
    chk("expire_pre", 16'(brake_state), 16'd1);
    tick();
    chk("expire_state", 16'(brake_state), 16'd2);
    chk("expire_int", 16'(brake_fault_int), 16'd1);
    tick();
    chk("expire_int_1cyc", 16'(brake_fault_int), 16'd0);
    chk("expire_pwm", 16'(brake_pwm), 16'd1);

    // Asynchronous reset in the middle of a cycle while in FAULT.
    #3 rst_n = 1'b0;
    #1;
    chk("arst_state", 16'(brake_state), 16'd0);
    chk("arst_fault", 16'(brake_fault), 16'd0);
    chk("arst_pwm", 16'(brake_pwm), 16'd0);
    model_reset();
    enable = 1'b0; ratio = 16'd600;
    @(negedge clk);
    rst_n = 1'b1;
    ticks(1500);

    for (int c = 0; c < 20000; c++) begin
      pulse  = ($urandom % 5000) == 0;
      enable = ($urandom % 4000) != 0;
      if ($urandom % 6000 == 0) timeout = 8'($urandom % 3);
      if ($urandom % 700 == 0)
        ratio = ($urandom % 3 == 0) ? 16'($urandom)
                                    : 16'($urandom % 1001);
      tick();
    end
    pulse = 1'b0;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
